stream_demux4: RTL and testbench

Four-way valid/ready stream router for the tinyrv1 datapath. It is the producer-side counterpart of the 4:1 selection mux. One input stream carries a 2-bit destination select per message, and each message is steered into one of four output streams. Each output has its own 2-entry FIFO, so a stalled consumer does not block traffic to the other outputs until its own buffer fills.

---
 rtl/stream_demux4.sv | 54 +++++
 tb/tb_stream_demux4.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/stream_demux4.sv
// stream_demux4: routes one valid/ready stream to four outputs, each with a 2-entry FIFO
module stream_demux4 #(
  parameter int nbits = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [1:0]       in_sel,
  input  logic [nbits-1:0] in_msg,
  output logic [3:0]       out_val,
  input  logic [3:0]       out_rdy,
  output logic [nbits-1:0] out0_msg,
  output logic [nbits-1:0] out1_msg,
  output logic [nbits-1:0] out2_msg,
  output logic [nbits-1:0] out3_msg
);
  logic [nbits-1:0] entry [4][2];
  logic [1:0]       cnt [4];
  logic [3:0]       head, tail, enq, deq;
  // in_rdy looks only at registered state so out_rdy never reaches it
  assign in_rdy   = cnt[in_sel] != 2'd2;
  assign out0_msg = entry[0][head[0]];
  assign out1_msg = entry[1][head[1]];
  assign out2_msg = entry[2][head[2]];
  assign out3_msg = entry[3][head[3]];
  // per-port enqueue/dequeue strobes; in_sel is ignored whenever in_val is low
  always_comb begin
    for (int i = 0; i < 4; i++) out_val[i] = cnt[i] != 2'd0;
    enq = (in_val && in_rdy) ? 4'd1 << in_sel : 4'd0;
    deq = out_val & out_rdy;
  end
  // FIFO state update; reset clears pointers, counts and storage
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      for (int i = 0; i < 4; i++) begin
        cnt[i]      <= '0;
        entry[i][0] <= '0;
        entry[i][1] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (enq[i]) begin
          entry[i][tail[i]] <= in_msg;
          tail[i]           <= ~tail[i];
        end
        if (deq[i]) head[i] <= ~head[i];
        cnt[i] <= cnt[i] + {1'b0, enq[i]} - {1'b0, deq[i]};
      end
    end
  end
endmodule

// File: tb/tb_stream_demux4.sv
// tb_stream_demux4: directed and scoreboard-based checks of the four-way stream router
module tb_stream_demux4;
  logic        clk = 0, rst = 1, in_val = 0, in_rdy;
  logic [1:0]  in_sel = 0;
  logic [31:0] in_msg = 0;
  logic [3:0]  out_val, out_rdy = 0;
  logic [31:0] out0_msg, out1_msg, out2_msg, out3_msg;
  logic [31:0] om [4];
  int n_cmp = 0, n_err = 0;

  stream_demux4 #(.nbits(32)) dut (
    .clk(clk), .rst(rst), .in_val(in_val), .in_rdy(in_rdy), .in_sel(in_sel), .in_msg(in_msg),
    .out_val(out_val), .out_rdy(out_rdy),
    .out0_msg(out0_msg), .out1_msg(out1_msg), .out2_msg(out2_msg), .out3_msg(out3_msg)
  );

  always #5 clk = ~clk;
  assign om[0] = out0_msg;
  assign om[1] = out1_msg;
  assign om[2] = out2_msg;
  assign om[3] = out3_msg;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; in_val = 0; out_rdy = 0;
    tick();
    rst = 0;
    #1;
    n_cmp++; if (out_val !== 4'b0000) begin n_err++; $display("FAIL reset_out_val got %b want 0000", out_val); end
    for (int i = 0; i < 4; i++) begin
      in_sel = 2'(i);
      #1;
      n_cmp++; if (in_rdy !== 1'b1) begin n_err++; $display("FAIL reset_in_rdy sel=%0d got %b want 1", i, in_rdy); end
      n_cmp++; if (om[i] !== 32'd0) begin n_err++; $display("FAIL reset_msg port=%0d got %h want 0", i, om[i]); end
    end
  endtask

  task automatic test_single();
    in_val = 1; in_sel = 2; in_msg = 32'hDEADBEEF; out_rdy = 0;
    tick();
    in_val = 0;
    #1;
    n_cmp++; if (out_val !== 4'b0100) begin n_err++; $display("FAIL single_val got %b want 0100", out_val); end
    n_cmp++; if (out2_msg !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_msg got %h want deadbeef", out2_msg); end
    n_cmp++; if (in_rdy !== 1'b1) begin n_err++; $display("FAIL single_in_rdy got %b want 1", in_rdy); end
    out_rdy = 4'b0100;
    tick();
    out_rdy = 0;
    n_cmp++; if (out_val !== 4'b0000) begin n_err++; $display("FAIL single_drain got %b want 0000", out_val); end
  endtask

  task automatic test_fill();
    out_rdy = 0; in_val = 1; in_sel = 1;
    in_msg = 32'h11; tick();
    in_msg = 32'h22; tick();
    in_val = 0;
    for (int i = 0; i < 4; i++) begin
      in_sel = 2'(i);
      #1;
      n_cmp++; if (in_rdy !== (i != 1)) begin n_err++; $display("FAIL fill_in_rdy sel=%0d got %b want %b", i, in_rdy, i != 1); end
    end
    in_val = 1; in_sel = 1; in_msg = 32'h33;
    tick();
    n_cmp++; if (out1_msg !== 32'h11) begin n_err++; $display("FAIL fill_hold got %h want 11", out1_msg); end
    n_cmp++; if (in_rdy !== 1'b0) begin n_err++; $display("FAIL fill_blocked got %b want 0", in_rdy); end
    out_rdy = 4'b0010;
    tick();
    out_rdy = 0;
    #1;
    n_cmp++; if (in_rdy !== 1'b1) begin n_err++; $display("FAIL fill_reopen got %b want 1", in_rdy); end
    tick();
    in_val = 0; out_rdy = 4'b0010;
    #1;
    n_cmp++; if (out1_msg !== 32'h22) begin n_err++; $display("FAIL fill_order1 got %h want 22", out1_msg); end
    tick();
    n_cmp++; if (out1_msg !== 32'h33) begin n_err++; $display("FAIL fill_order2 got %h want 33", out1_msg); end
    tick();
    out_rdy = 0;
    n_cmp++; if (out_val !== 4'b0000) begin n_err++; $display("FAIL fill_empty got %b want 0000", out_val); end
  endtask

  task automatic test_simul();
    out_rdy = 0; in_val = 1; in_sel = 3; in_msg = 32'hA;
    tick();
    in_msg = 32'hB; out_rdy = 4'b1000;
    #1;
    n_cmp++; if (in_rdy !== 1'b1) begin n_err++; $display("FAIL simul_in_rdy got %b want 1", in_rdy); end
    tick();
    in_val = 0; out_rdy = 0;
    n_cmp++; if (out_val !== 4'b1000) begin n_err++; $display("FAIL simul_val got %b want 1000", out_val); end
    n_cmp++; if (out3_msg !== 32'hB) begin n_err++; $display("FAIL simul_msg got %h want b", out3_msg); end
    out_rdy = 4'b1000;
    tick();
    out_rdy = 0;
    n_cmp++; if (out_val !== 4'b0000) begin n_err++; $display("FAIL simul_drain got %b want 0000", out_val); end
  endtask

  task automatic test_round_robin();
    out_rdy = 4'b1111;
    for (int k = 0; k < 16; k++) begin
      in_val = 1; in_sel = 2'(k % 4); in_msg = 32'(k);
      #1;
      n_cmp++; if (in_rdy !== 1'b1) begin n_err++; $display("FAIL rr_in_rdy k=%0d got %b want 1", k, in_rdy); end
      tick();
      n_cmp++; if (out_val !== 4'(1 << (k % 4))) begin n_err++; $display("FAIL rr_val k=%0d got %b want %b", k, out_val, 4'(1 << (k % 4))); end
      n_cmp++; if (om[k % 4] !== 32'(k)) begin n_err++; $display("FAIL rr_msg k=%0d got %h want %h", k, om[k % 4], k); end
    end
    in_val = 0;
    tick();
    out_rdy = 0;
  endtask

  task automatic test_stress();
    logic [31:0] q [4][$];
    bit ev;
    for (int c = 0; c < 10000; c++) begin
      in_val = 1'($urandom_range(0, 1));
      in_sel = 2'($urandom_range(0, 3));
      in_msg = $urandom;
      out_rdy = 4'($urandom_range(0, 15));
      #1;
      ev = in_val && q[in_sel].size() != 2;
      if (in_val) begin
        n_cmp++; if (in_rdy !== (q[in_sel].size() != 2)) begin n_err++; $display("FAIL stress_in_rdy c=%0d sel=%0d got %b", c, in_sel, in_rdy); end
      end
      for (int i = 0; i < 4; i++) begin
        n_cmp++; if (out_val[i] !== (q[i].size() != 0)) begin n_err++; $display("FAIL stress_val c=%0d port=%0d got %b want %b", c, i, out_val[i], q[i].size() != 0); end
        if (q[i].size() != 0) begin
          n_cmp++; if (om[i] !== q[i][0]) begin n_err++; $display("FAIL stress_msg c=%0d port=%0d got %h want %h", c, i, om[i], q[i][0]); end
          if (out_rdy[i]) void'(q[i].pop_front());
        end
      end
      if (ev) q[in_sel].push_back(in_msg);
      tick();
    end
    in_val = 0; out_rdy = 0;
  endtask

  task automatic test_reset_mid();
    out_rdy = 0; in_val = 1;
    in_sel = 0; in_msg = 32'h100; tick();
    in_msg = 32'h101; tick();
    in_sel = 3; in_msg = 32'h300; tick();
    in_val = 0;
    #1;
    n_cmp++; if (out_val !== 4'b1001) begin n_err++; $display("FAIL mid_pre got %b want 1001", out_val); end
    rst = 1; in_val = 1; in_sel = 1; in_msg = 32'h55;
    tick();
    rst = 0; in_val = 0;
    #1;
    n_cmp++; if (out_val !== 4'b0000) begin n_err++; $display("FAIL mid_val got %b want 0000", out_val); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (om[i] !== 32'd0) begin n_err++; $display("FAIL mid_msg port=%0d got %h want 0", i, om[i]); end
    end
    tick();
    n_cmp++; if (out_val !== 4'b0000) begin n_err++; $display("FAIL mid_no_enq got %b want 0000", out_val); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_simul();
    test_round_robin();
    test_stress();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
